hms_hex_display: RTL and testbench
==================================

// Module: hms_hex_display
// PURPOSE
// - Downstream of the time-of-day counter. Takes binary hour/min/sec and drives the 4 active-low HEX digits.
// - Shows HH:MM or MM:SS.
// - Converts each field to BCD with a sequential shift-add-3 (double-dabble) engine, then encodes to 7 segments.
// - Blinks the field being set while set mode is active.
// PARAMETERS
// - CLK_HZ      50_000_000  clk frequency in Hz
// - BLINK_HZ    2           blink rate in Hz; half-period HALF = CLK_HZ/(2*BLINK_HZ) cycles, must be >= 1
// - SAMPLE_DIV  50_000      cycles between input samples; must be >= 16
// PORTS
// - clk      in   1  system clock; everything is on its rising edge
// - rst      in   1  synchronous, active-high reset
// - hour     in   5  binary hour, legal range 0..23
// - min      in   6  binary minute, legal range 0..59
// - sec      in   6  binary second, legal range 0..59
// - showSec  in   1  0 = HH:MM view, 1 = MM:SS view
// - setMode  in   1  1 = a field is being set (enables blinking)
// - sethms   in   2  field being set: 00 = hour, 01 = min, 10 = sec, 11 = none
// - hex3     out  7  leftmost digit, active low, bit order gfedcba
// - hex2     out  7  second digit from left, same encoding
// - hex1     out  7  third digit from left, same encoding
// - hex0     out  7  rightmost digit, same encoding
// BEHAVIOUR
// Interface and reset
// - One clock, clk. Reset rst is synchronous, active high.
// - Reset: hex3..hex0 = 7'h7F (blank); FSM to IDLE; sample counter and blink counter cleared; blink phase = visible.
// - Reset mid-conversion aborts the conversion; no partial result is ever loaded.
// Sampling
// - sampCnt counts 0..SAMPLE_DIV-1 and wraps; strobe = (sampCnt == SAMPLE_DIV-1).
// - First strobe occurs SAMPLE_DIV-1 cycles after reset is released.
// FSM: IDLE -> CONV -> LOAD -> IDLE
// - IDLE: on strobe, latch the view and fields.
//   - showSec = 0: left field = hour, right field = min.
//   - showSec = 1: left field = min, right field = sec.
// - CONV: exactly 12 cycles, 6 double-dabble iterations for the left field then 6 for the right. Each result is 8-bit BCD.
// - LOAD: 1 cycle. Encode the 4 BCD digits into the internal segment registers seg3..seg0.
// - Latency: strobe in cycle T; LOAD in T+13; hex ports show the new value from T+14.
// - Inputs that change after the strobe edge have no effect until the next strobe, including showSec.
// Out-of-range handling
// - Applies to hour > 23 and to min/sec > 59.
// - Both digits of that field encode as dash 7'h3F. The other field is unaffected.
// Segment codes
// - 0..9 = 40, 79, 24, 30, 19, 12, 02, 78, 00, 10 (hex).
// Blink
// - blinkCnt counts 0..HALF-1; phase toggles on wrap.
// - On each cycle, hexN <= (blankN ? 7'h7F : segN).
// - blankN is true when phase = off AND setMode = 1 AND sethms selects the field currently latched in digit N's position.
// - Selecting a field not shown in the current view (e.g. sethms = 10 in HH:MM) blanks nothing.
// - sethms = 11 blanks nothing.
// - setMode and sethms are applied live, with 1 cycle of latency; they are not latched by the strobe.
// Simultaneous events
// - rst has priority over everything.
// - The blink toggle and LOAD in the same cycle are independent: the new seg values and the new phase both take effect at the next edge.
// CONFIGURATION
// - LEADING_ZERO_BLANK_EN defined: when the left field is hour and its tens digit is 0, seg3 = 7'h7F instead of 7'h40.
// - LEADING_ZERO_BLANK_EN undefined: the hour tens digit always shows, including 0 (7'h40).
// - In both builds, minute and second tens digits always show.
// TESTING (bench params: CLK_HZ=16, BLINK_HZ=2, SAMPLE_DIV=16 -> HALF=4)
// - Reset: rst high 2 cycles -> hex3..0 = 7F; first strobe 15 cycles after release; hex valid 14 cycles later.
// - View: hour=23, min=59, showSec=0 -> hex3..0 = 24, 30, 12, 10 at strobe+14.
//   - Then showSec=1, sec=7 -> next sample shows 12, 10, 40, 78.
// - Range: hour=24, min=5 -> hex3..0 = 3F, 3F, 40, 12.
//   - min=60 in MM:SS view -> left pair = 3F, 3F.
// - Blink: setMode=1, sethms=01, HH:MM view, hour=12, min=34 -> hex1/hex0 alternate 30,19 / 7F,7F every 4 cycles.
//   - hex3/hex2 stay 79,24.
//   - sethms=10 in the same view -> no digit blanks.
// - Stability: change min 1 cycle after the strobe -> old value held until the following strobe.
//   - rst asserted during CONV -> hex goes to 7F next cycle; no stale LOAD follows.
// - Macro: hour=5, min=0, built with LEADING_ZERO_BLANK_EN -> hex3 = 7F, hex2 = 12.
//   - Built without the macro -> hex3 = 40.

Source files
------------

// File: rtl/hms_hex_display.sv
// hms_hex_display
// Takes binary hour/min/sec from the time-of-day counter and drives four
// active-low seven-segment digits (bit order gfedcba). The display shows
// either HH:MM or MM:SS. Each field is converted to BCD by a sequential
// double-dabble engine. While set mode is active, the field being edited
// blinks.
//
// Ports
//   clk      : system clock; all logic runs on its rising edge
//   rst      : synchronous, active-high reset
//   hour     : binary hour, 0..23 (larger values display as dashes)
//   min      : binary minute, 0..59 (larger values display as dashes)
//   sec      : binary second, 0..59 (larger values display as dashes)
//   showSec  : 0 = HH:MM view, 1 = MM:SS view (latched on each sample)
//   setMode  : 1 = a field is being edited; enables blinking (live)
//   sethms   : field being edited: 00 hour, 01 min, 10 sec, 11 none (live)
//   hex3     : leftmost digit, active low
//   hex2     : second digit from the left
//   hex1     : third digit from the left
//   hex0     : rightmost digit
//
// Build option
//   LEADING_ZERO_BLANK_EN : when this macro is defined, the hour tens digit
//                           is blanked when it is zero. Minute and second
//                           tens digits always show.
module hms_hex_display #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BLINK_HZ   = 2,
  parameter int SAMPLE_DIV = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic       showSec,
  input  logic       setMode,
  input  logic [1:0] sethms,
  output logic [6:0] hex3,
  output logic [6:0] hex2,
  output logic [6:0] hex1,
  output logic [6:0] hex0
);

  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int SW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [SW-1:0] SAMP_LAST  = SW'(SAMPLE_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(HALF - 1);
  localparam logic [6:0]    SEG_BLANK  = 7'h7F;
  localparam logic [6:0]    SEG_DASH   = 7'h3F;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ_BLANK = 1'b1;
`else
  localparam bit LZ_BLANK = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  // Digit value to active-low segment pattern (gfedcba).
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // One double-dabble iteration on {tens, ones, binary}: add 3 to any BCD
  // digit >= 5, then shift the whole register left by one.
  function automatic logic [13:0] dd_step(input logic [13:0] s);
    logic [3:0]  t;
    logic [3:0]  o;
    logic [13:0] v;
    t = s[13:10];
    o = s[9:6];
    if (o >= 4'd5) o = o + 4'd3;
    if (t >= 4'd5) t = t + 4'd3;
    v = {t, o, s[5:0]};
    return v << 1;
  endfunction

  // Control state
  state_t        state;
  state_t        state_next;
  logic [SW-1:0] samp_cnt;
  logic          strobe;
  logic [3:0]    conv_cnt;
  logic [BW-1:0] blink_cnt;
  logic          phase_off;
  logic          disp_view;

  // Sampled fields and conversion datapath
  logic          view_p0;
  logic [5:0]    right_bin_p0;
  logic          left_bad_p0;
  logic          right_bad_p0;
  logic [5:0]    left_in;
  logic [13:0]   shreg_p1;
  logic [13:0]   dd_next;
  logic [7:0]    left_bcd_p1;
  logic [7:0]    right_bcd_p1;

  // Segment registers and display selection
  logic [6:0]    seg3, seg2, seg1, seg0;
  logic [6:0]    enc3, enc2, enc1, enc0;
  logic [6:0]    seg3_d, seg2_d, seg1_d, seg0_d;
  logic          view_d;
  logic [1:0]    left_code;
  logic [1:0]    right_code;
  logic          blank_left;
  logic          blank_right;

  // Sample timebase
  assign strobe = (samp_cnt == SAMP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_cnt <= '0;
    end else if (strobe) begin
      samp_cnt <= '0;
    end else begin
      samp_cnt <= samp_cnt + 1'b1;
    end
  end

  // Blink timebase
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      phase_off <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase_off <= ~phase_off;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Conversion FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (strobe) state_next = CONV;
      CONV:    if (conv_cnt == 4'd11) state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conv_cnt <= '0;
    end else if (state == IDLE) begin
      conv_cnt <= '0;
    end else if (state == CONV) begin
      conv_cnt <= conv_cnt + 4'd1;
    end
  end

  // Stage p0: latch view and both fields on the sample strobe
  assign left_in = showSec ? min : {1'b0, hour};
  assign dd_next = dd_step(shreg_p1);

  always_ff @(posedge clk) begin
    if (state == IDLE && strobe) begin
      view_p0      <= showSec;
      right_bin_p0 <= showSec ? sec : min;
      left_bad_p0  <= showSec ? (min > 6'd59) : (hour > 5'd23);
      right_bad_p0 <= showSec ? (sec > 6'd59) : (min > 6'd59);
      shreg_p1     <= {8'd0, left_in};
    end else if (state == CONV) begin
      // Stage p1: six iterations on the left field, then six on the right
      if (conv_cnt == 4'd5) begin
        left_bcd_p1 <= dd_next[13:6];
        shreg_p1    <= {8'd0, right_bin_p0};
      end else if (conv_cnt == 4'd11) begin
        right_bcd_p1 <= dd_next[13:6];
        shreg_p1     <= dd_next;
      end else begin
        shreg_p1 <= dd_next;
      end
    end
  end

  // Stage p2: BCD digits to segment patterns, with dash for out-of-range
  always_comb begin
    enc3 = seg7(left_bcd_p1[7:4]);
    enc2 = seg7(left_bcd_p1[3:0]);
    enc1 = seg7(right_bcd_p1[7:4]);
    enc0 = seg7(right_bcd_p1[3:0]);
    if (LZ_BLANK && !view_p0 && left_bcd_p1[7:4] == 4'd0) begin
      enc3 = SEG_BLANK;
    end
    if (left_bad_p0) begin
      enc3 = SEG_DASH;
      enc2 = SEG_DASH;
    end
    if (right_bad_p0) begin
      enc1 = SEG_DASH;
      enc0 = SEG_DASH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg3      <= SEG_BLANK;
      seg2      <= SEG_BLANK;
      seg1      <= SEG_BLANK;
      seg0      <= SEG_BLANK;
      disp_view <= 1'b0;
    end else if (state == LOAD) begin
      seg3      <= enc3;
      seg2      <= enc2;
      seg1      <= enc1;
      seg0      <= enc0;
      disp_view <= view_p0;
    end
  end

  // The output register takes the freshly encoded digits during LOAD so the
  // new value appears one edge after LOAD rather than two.
  assign seg3_d = (state == LOAD) ? enc3 : seg3;
  assign seg2_d = (state == LOAD) ? enc2 : seg2;
  assign seg1_d = (state == LOAD) ? enc1 : seg1;
  assign seg0_d = (state == LOAD) ? enc0 : seg0;
  assign view_d = (state == LOAD) ? view_p0 : disp_view;

  // The field codes follow the view that owns the digits being displayed.
  // Code 11 never matches either field, so it blanks nothing.
  assign left_code   = view_d ? 2'b01 : 2'b00;
  assign right_code  = view_d ? 2'b10 : 2'b01;
  assign blank_left  = phase_off && setMode && (sethms == left_code);
  assign blank_right = phase_off && setMode && (sethms == right_code);

  always_ff @(posedge clk) begin
    if (rst) begin
      hex3 <= SEG_BLANK;
      hex2 <= SEG_BLANK;
      hex1 <= SEG_BLANK;
      hex0 <= SEG_BLANK;
    end else begin
      hex3 <= blank_left  ? SEG_BLANK : seg3_d;
      hex2 <= blank_left  ? SEG_BLANK : seg2_d;
      hex1 <= blank_right ? SEG_BLANK : seg1_d;
      hex0 <= blank_right ? SEG_BLANK : seg0_d;
    end
  end

endmodule

// File: tb/tb_hms_hex_display.sv
module tb_hms_hex_display;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic       showSec;
  logic       setMode;
  logic [1:0] sethms;
  logic [6:0] hex3, hex2, hex1, hex0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [27:0] sb[$];

  hms_hex_display #(
    .CLK_HZ(16),
    .BLINK_HZ(2),
    .SAMPLE_DIV(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hour(hour),
    .min(min),
    .sec(sec),
    .showSec(showSec),
    .setMode(setMode),
    .sethms(sethms),
    .hex3(hex3),
    .hex2(hex2),
    .hex1(hex1),
    .hex0(hex0)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; equals the sample count before wrapping.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [13:0] pair(input int v, input int lim, input bit lz);
    if (v > lim) return {7'h3F, 7'h3F};
    if (lz && v < 10) return {7'h7F, seg_of(v % 10)};
    return {seg_of(v / 10), seg_of(v % 10)};
  endfunction

  function automatic logic [27:0] model(input int h, input int m, input int s, input bit v);
    if (v) return {pair(m, 59, 1'b0), pair(s, 59, 1'b0)};
    return {pair(h, 23, LZ), pair(m, 59, 1'b0)};
  endfunction

  task automatic goto_cyc(input int target);
    int n;
    n = 0;
    while (cyc != target && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (cyc != target) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_cyc: cycle %0d reached, wanted %0d", cyc, target);
    end
  endtask

  // Moves to the negedge inside the next strobe cycle.
  task automatic goto_strobe();
    int n;
    n = 0;
    @(negedge clk);
    while (cyc % 16 != 15 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (cyc % 16 != 15) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_strobe: cycle %0d never reached a strobe", cyc);
    end
  endtask

  task automatic apply_sample(input int h, input int m, input int s, input bit v, output int t);
    goto_strobe();
    hour    = 5'(h);
    min     = 6'(m);
    sec     = 6'(s);
    showSec = v;
    t       = cyc;
    sb.push_back(model(h, m, s, v));
  endtask

  task automatic test_reset();
    logic [27:0] got, want;
    rst = 1'b1; hour = 5'd1; min = 6'd2; sec = 6'd3;
    showSec = 1'b0; setMode = 1'b0; sethms = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sb.push_back({4{7'h7F}});
    got = {hex3, hex2, hex1, hex0}; want = sb.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL reset_hold: got %07h want %07h", got, want); end
    rst = 1'b0;
    goto_cyc(10);
    sb.push_back({4{7'h7F}});
    got = {hex3, hex2, hex1, hex0}; want = sb.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL reset_idle: got %07h want %07h", got, want); end
    goto_cyc(28);
    sb.push_back({4{7'h7F}});
    got = {hex3, hex2, hex1, hex0}; want = sb.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL pre_first_load: got %07h want %07h", got, want); end
    sb.push_back(model(1, 2, 3, 1'b0));
    goto_cyc(29);
    got = {hex3, hex2, hex1, hex0}; want = sb.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL first_load: got %07h want %07h", got, want); end
  endtask

  task automatic test_view();
    logic [27:0] got, want;
    int t;
    apply_sample(23, 59, 0, 1'b0, t);
    goto_cyc(t + 14);
    got = {hex3, hex2, hex1, hex0}; want = sb.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL view_hhmm: got %07h want %07h", got, want); end
    apply_sample(23, 59, 7, 1'b1, t);
    goto_cyc(t + 14);
    got = {hex3, hex2, hex1, hex0}; want = sb.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL view_mmss: got %07h want %07h", got, want); end
    if (got !== {7'h12, 7'h10, 7'h40, 7'h78}) begin
      miscompares++; $display("FAIL view_mmss_const: got %07h want %07h", got, {7'h12, 7'h10, 7'h40, 7'h78});
    end
    vectors++;
  endtask

  task automatic test_range();
    logic [27:0] got, want;
    int t;
    apply_sample(24, 5, 0, 1'b0, t);
    goto_cyc(t + 14);
    got = {hex3, hex2, hex1, hex0}; want = sb.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL range_hour24: got %07h want %07h", got, want); end
    apply_sample(0, 60, 7, 1'b1, t);
    goto_cyc(t + 14);
    got = {hex3, hex2, hex1, hex0}; want = sb.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL range_min60: got %07h want %07h", got, want); end
    apply_sample(0, 59, 60, 1'b1, t);
    goto_cyc(t + 14);
    got = {hex3, hex2, hex1, hex0}; want = sb.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL range_sec60: got %07h want %07h", got, want); end
  endtask

  task automatic test_blink();
    logic [27:0] got, want;
    int t;
    setMode = 1'b1;
    sethms  = 2'b01;
    apply_sample(12, 34, 0, 1'b0, t);
    void'(sb.pop_front());
    goto_cyc(t + 14);
    for (int i = 0; i < 12; i++) begin
      want = model(12, 34, 0, 1'b0);
      if (((cyc - 1) / 4) % 2 == 1) want[13:0] = {7'h7F, 7'h7F};
      sb.push_back(want);
      got = {hex3, hex2, hex1, hex0}; want = sb.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL blink_min cyc %0d: got %07h want %07h", cyc, got, want); end
      @(negedge clk);
    end
    sethms = 2'b10;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      sb.push_back(model(12, 34, 0, 1'b0));
      got = {hex3, hex2, hex1, hex0}; want = sb.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL blink_hidden cyc %0d: got %07h want %07h", cyc, got, want); end
      @(negedge clk);
    end
    sethms = 2'b00;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      want = model(12, 34, 0, 1'b0);
      if (((cyc - 1) / 4) % 2 == 1) want[27:14] = {7'h7F, 7'h7F};
      sb.push_back(want);
      got = {hex3, hex2, hex1, hex0}; want = sb.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL blink_hour cyc %0d: got %07h want %07h", cyc, got, want); end
      @(negedge clk);
    end
    setMode = 1'b0;
    sethms  = 2'b11;
  endtask

  task automatic test_stability();
    logic [27:0] got, want;
    int t;
    apply_sample(10, 20, 0, 1'b0, t);
    goto_cyc(t + 14);
    got = {hex3, hex2, hex1, hex0}; want = sb.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL stable_base: got %07h want %07h", got, want); end
    goto_strobe();
    t = cyc;
    sb.push_back(model(10, 20, 0, 1'b0));
    @(negedge clk);
    min = 6'd45; sec = 6'd9; showSec = 1'b1;
    goto_cyc(t + 14);
    got = {hex3, hex2, hex1, hex0}; want = sb.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL stable_hold: got %07h want %07h", got, want); end
    sb.push_back(model(10, 45, 9, 1'b1));
    goto_cyc(t + 30);
    got = {hex3, hex2, hex1, hex0}; want = sb.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL stable_next: got %07h want %07h", got, want); end
  endtask

  task automatic test_rst_conv();
    logic [27:0] got, want;
    int t;
    apply_sample(7, 8, 9, 1'b0, t);
    goto_cyc(t + 14);
    got = {hex3, hex2, hex1, hex0}; want = sb.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL rst_conv_pre: got %07h want %07h", got, want); end
    apply_sample(13, 27, 0, 1'b0, t);
    void'(sb.pop_front());
    goto_cyc(t + 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.push_back({4{7'h7F}});
    got = {hex3, hex2, hex1, hex0}; want = sb.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL rst_conv_blank: got %07h want %07h", got, want); end
    goto_cyc(12);
    sb.push_back({4{7'h7F}});
    got = {hex3, hex2, hex1, hex0}; want = sb.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL rst_no_stale: got %07h want %07h", got, want); end
    sb.push_back(model(13, 27, 0, 1'b0));
    goto_cyc(29);
    got = {hex3, hex2, hex1, hex0}; want = sb.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL rst_recover: got %07h want %07h", got, want); end
  endtask

  task automatic test_leading_zero();
    logic [27:0] got, want;
    int t;
    apply_sample(5, 0, 0, 1'b0, t);
    void'(sb.pop_front());
    sb.push_back({(LZ ? 7'h7F : 7'h40), 7'h12, 7'h40, 7'h40});
    goto_cyc(t + 14);
    got = {hex3, hex2, hex1, hex0}; want = sb.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL leading_zero: got %07h want %07h", got, want); end
    apply_sample(3, 5, 4, 1'b1, t);
    goto_cyc(t + 14);
    got = {hex3, hex2, hex1, hex0}; want = sb.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL min_tens_zero: got %07h want %07h", got, want); end
  endtask

  initial begin
    test_reset();
    test_view();
    test_range();
    test_blink();
    test_stability();
    test_rst_conv();
    test_leading_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
